// File: rtl/noc_xy_router_core.sv
// Registered Y-then-X route, round-robin arbitration, wormhole locking and
// downstream credit tracking for a 5-port mesh router (0=N 1=S 2=E 3=W 4=L).
module noc_xy_router_core #(
  parameter int XCOORD  = 0,
  parameter int YCOORD  = 0,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int DATA_W  = 16,
  parameter int CREDITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          in_valid_i,
  input  logic [5*DATA_W-1:0] in_data_i,
  output logic [4:0]          in_pop_o,
  output logic [4:0]          credit_ret_o,
  output logic [4:0]          out_valid_o,
  output logic [14:0]         out_sel_o,
  input  logic [4:0]          out_credit_i,
  output logic                err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [X_W-1:0] MY_X = X_W'(XCOORD);
  localparam logic [Y_W-1:0] MY_Y = Y_W'(YCOORD);

  logic [2:0]    route_q [5];
  logic [4:0]    open_q;
  logic [4:0]    lock_q;
  logic [2:0]    owner_q [5];
  logic [2:0]    rr_q    [5];
  logic [CW-1:0] cred_q  [5];

  logic [4:0] head, tail, req, drop, pop, xfer, sat;
  logic [2:0] tgt [5];
  logic [2:0] win [5];
  logic [2:0] idx;
  logic [3:0] sum;

  function automatic logic [2:0] route_of(input logic [DATA_W-1:0] f);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    dx = f[X_W+Y_W-1:Y_W];
    dy = f[Y_W-1:0];
    if (dy > MY_Y)      return 3'd1;
    else if (dy < MY_Y) return 3'd0;
    else if (dx > MY_X) return 3'd2;
    else if (dx < MY_X) return 3'd3;
    else                return 3'd4;
  endfunction

  // Body and tail flits follow the route latched from their head; anything
  // that cannot legally go anywhere is dropped without needing a grant.
  always_comb begin : decode
    for (int p = 0; p < 5; p++) begin
      head[p] = in_data_i[p*DATA_W + DATA_W-1];
      tail[p] = in_data_i[p*DATA_W + DATA_W-2];
      tgt[p]  = in_data_i[p*DATA_W + DATA_W-1] ?
                route_of(in_data_i[p*DATA_W +: DATA_W]) : route_q[p];
      req[p]  = in_valid_i[p] &&
                (in_data_i[p*DATA_W + DATA_W-1] ? (tgt[p] != 3'(p)) : open_q[p]);
      drop[p] = in_valid_i[p] && !req[p];
    end
  end

  always_comb begin : arbitrate
    xfer = '0;
    pop  = '0;
    idx  = '0;
    sum  = '0;
    for (int q = 0; q < 5; q++) begin
      win[q] = '0;
      if (cred_q[q] != '0) begin
        if (lock_q[q]) begin
          if (req[owner_q[q]] && tgt[owner_q[q]] == 3'(q)) begin
            xfer[q] = 1'b1;
            win[q]  = owner_q[q];
          end
        end else begin
          for (int k = 0; k < 5; k++) begin
            sum = {1'b0, rr_q[q]} + 4'(k);
            if (sum >= 4'd5) sum = sum - 4'd5;
            idx = sum[2:0];
            if (!xfer[q] && req[idx] && head[idx] && tgt[idx] == 3'(q)) begin
              xfer[q] = 1'b1;
              win[q]  = idx;
            end
          end
        end
      end
      if (xfer[q]) pop[win[q]] = 1'b1;
      sat[q] = out_credit_i[q] && !xfer[q] && cred_q[q] == CW'(CREDITS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= '0;
      open_q <= '0;
      for (int q = 0; q < 5; q++) begin
        owner_q[q] <= '0;
        rr_q[q]    <= '0;
        cred_q[q]  <= CW'(CREDITS);
        route_q[q] <= '0;
      end
    end else begin
      for (int q = 0; q < 5; q++) begin
        if (xfer[q]) begin
          if (!lock_q[q]) begin
            rr_q[q] <= (win[q] == 3'd4) ? 3'd0 : win[q] + 3'd1;
            if (!tail[win[q]]) begin
              lock_q[q]  <= 1'b1;
              owner_q[q] <= win[q];
            end
          end else if (tail[win[q]]) begin
            lock_q[q] <= 1'b0;
          end
        end
        case ({xfer[q], out_credit_i[q]})
          2'b10:   cred_q[q] <= cred_q[q] - CW'(1);
          2'b01:   if (!sat[q]) cred_q[q] <= cred_q[q] + CW'(1);
          default: ;
        endcase
      end
      for (int p = 0; p < 5; p++) begin
        if (pop[p]) begin
          if (head[p]) begin
            route_q[p] <= tgt[p];
            open_q[p]  <= !tail[p];
          end else if (tail[p]) begin
            open_q[p] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin : drive
    in_pop_o    = '0;
    out_valid_o = '0;
    out_sel_o   = '0;
    err_o       = 1'b0;
    if (!reset) begin
      in_pop_o    = pop | drop;
      out_valid_o = xfer;
      for (int q = 0; q < 5; q++) out_sel_o[q*3 +: 3] = win[q];
      err_o = (|drop) || (|sat);
    end
  end

  assign credit_ret_o = in_pop_o;

endmodule

// File: tb/tb_noc_xy_router_core.sv
// Directed scoreboard bench for noc_xy_router_core at XCOORD=1, YCOORD=1:
// stimulus queues expected transfers/drops, a negedge monitor retires them.
module tb_noc_xy_router_core;

  localparam int PN = 0;
  localparam int PS = 1;
  localparam int PE = 2;
  localparam int PW = 3;
  localparam int PL = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  in_valid_i;
  logic [79:0] in_data_i;
  logic [4:0]  in_pop_o;
  logic [4:0]  credit_ret_o;
  logic [4:0]  out_valid_o;
  logic [14:0] out_sel_o;
  logic [4:0]  out_credit_i;
  logic        err_o;

  typedef struct {
    bit is_err;
    int port;
    int sel;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] flits [5];
  int          vectors;
  int          miscompares;
  bit          mon_on;

  noc_xy_router_core #(
    .XCOORD(1), .YCOORD(1), .X_W(4), .Y_W(4), .DATA_W(16), .CREDITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_pop_o(in_pop_o),
    .credit_ret_o(credit_ret_o),
    .out_valid_o(out_valid_o),
    .out_sel_o(out_sel_o),
    .out_credit_i(out_credit_i),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input bit h, input bit t, input int x, input int y);
    logic [3:0] xs;
    logic [3:0] ys;
    xs = x[3:0];
    ys = y[3:0];
    return {h, t, 6'b0, xs, ys};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expXfer(input int q, input int sel);
    exp_t e;
    e.is_err = 1'b0;
    e.port   = q;
    e.sel    = sel;
    sb.push_back(e);
  endtask

  task automatic expErr(input int port);
    exp_t e;
    e.is_err = 1'b1;
    e.port   = port;
    e.sel    = 0;
    sb.push_back(e);
  endtask

  task automatic clearFlits();
    for (int p = 0; p < 5; p++) flits[p] = '0;
  endtask

  task automatic applyStimulus(input logic [4:0] valid, input logic [4:0] credit);
    in_valid_i   = valid;
    out_credit_i = credit;
    for (int p = 0; p < 5; p++) in_data_i[p*16 +: 16] = flits[p];
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire one scoreboard entry per presented transfer or error pulse.
  always @(negedge clk) begin
    logic [4:0] exp_pop;
    exp_t       e;
    if (mon_on) begin
      if (reset) begin
        checkOutput("reset_quiet",
                    {8'b0, in_pop_o, credit_ret_o, out_valid_o, err_o, out_sel_o}, 32'd0);
      end else begin
        exp_pop = '0;
        for (int q = 0; q < 5; q++) begin
          if (out_valid_o[q]) begin
            checkOutput("xfer_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              checkOutput("xfer_route", 32'((q << 4) | int'(out_sel_o[q*3 +: 3])),
                          e.is_err ? 32'hFFF : 32'((e.port << 4) | e.sel));
              if (!e.is_err) exp_pop[e.sel] = 1'b1;
            end
          end
        end
        if (err_o) begin
          checkOutput("err_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("err_pulse", 32'(err_o), 32'(e.is_err));
            if (e.is_err && e.port >= 0) exp_pop[e.port] = 1'b1;
          end
        end
        checkOutput("in_pop", 32'(in_pop_o), 32'(exp_pop));
        checkOutput("credit_ret", 32'(credit_ret_o), 32'(exp_pop));
      end
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    mon_on       = 1'b0;
    reset        = 1'b1;
    in_valid_i   = '0;
    in_data_i    = '0;
    out_credit_i = '0;
    clearFlits();
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Reset held with live traffic on the inputs: everything stays quiet.
    flits[PL] = mk(1, 1, 1, 3);
    applyStimulus(5'b10000, 5'b00000);
    applyStimulus(5'b10000, 5'b00010);
    reset = 1'b0;
    clearFlits();
    applyStimulus(5'b00000, 5'b00000);

    // Single-flit L packet to (1,3) leaves on S; then return the credit.
    flits[PL] = mk(1, 1, 1, 3);
    expXfer(PS, PL);
    applyStimulus(5'b10000, 5'b00000);
    clearFlits();
    applyStimulus(5'b00000, 5'b00010);

    // N, E, W all contend for L with credits refilled every cycle.
    flits[PN] = mk(1, 1, 1, 1);
    flits[PE] = mk(1, 1, 1, 1);
    flits[PW] = mk(1, 1, 1, 1);
    expXfer(PL, PN); applyStimulus(5'b01101, 5'b10000);
    expXfer(PL, PE); applyStimulus(5'b01101, 5'b10000);
    expXfer(PL, PW); applyStimulus(5'b01101, 5'b10000);
    expXfer(PL, PN); applyStimulus(5'b01101, 5'b10000);
    expXfer(PL, PE); applyStimulus(5'b01101, 5'b10000);
    clearFlits();
    applyStimulus(5'b00000, 5'b00000);

    // W holds E for a 3-flit packet while L waits with a head for E.
    flits[PL] = mk(1, 1, 2, 1);
    flits[PW] = mk(1, 0, 2, 1);
    expXfer(PE, PW); applyStimulus(5'b11000, 5'b00000);
    flits[PW] = mk(0, 0, 0, 0);
    expXfer(PE, PW); applyStimulus(5'b11000, 5'b00000);
    flits[PW] = mk(0, 1, 0, 0);
    expXfer(PE, PW); applyStimulus(5'b11000, 5'b00000);
    flits[PW] = '0;
    expXfer(PE, PL); applyStimulus(5'b10000, 5'b00000);
    clearFlits();
    for (int i = 0; i < 4; i++) applyStimulus(5'b00000, 5'b00100);

    // Credit exhaustion on S, a simultaneous credit/stall, then release.
    flits[PL] = mk(1, 1, 1, 3);
    for (int i = 0; i < 4; i++) begin
      expXfer(PS, PL);
      applyStimulus(5'b10000, 5'b00000);
    end
    applyStimulus(5'b10000, 5'b00000);
    applyStimulus(5'b10000, 5'b00010);
    expXfer(PS, PL);
    applyStimulus(5'b10000, 5'b00000);
    clearFlits();
    for (int i = 0; i < 4; i++) applyStimulus(5'b00000, 5'b00010);
    expErr(-1);
    applyStimulus(5'b00000, 5'b00010);

    // Illegal flits: U-turn head on N, orphan body flit on E.
    flits[PN] = mk(1, 1, 1, 0);
    expErr(PN);
    applyStimulus(5'b00001, 5'b00000);
    clearFlits();
    flits[PE] = mk(0, 0, 1, 1);
    expErr(PE);
    applyStimulus(5'b00100, 5'b00000);
    clearFlits();
    applyStimulus(5'b00000, 5'b00000);

    // Reset in the middle of a W->E packet abandons it.
    flits[PW] = mk(1, 0, 2, 1);
    expXfer(PE, PW); applyStimulus(5'b01000, 5'b00000);
    flits[PW] = mk(0, 0, 0, 0);
    expXfer(PE, PW); applyStimulus(5'b01000, 5'b00000);
    reset = 1'b1;
    applyStimulus(5'b01000, 5'b00000);
    applyStimulus(5'b01000, 5'b00000);
    reset = 1'b0;
    expErr(PW); applyStimulus(5'b01000, 5'b00000);
    flits[PW] = mk(0, 1, 0, 0);
    expErr(PW); applyStimulus(5'b01000, 5'b00000);
    clearFlits();
    flits[PL] = mk(1, 1, 2, 1);
    expXfer(PE, PL); applyStimulus(5'b10000, 5'b00000);
    clearFlits();
    applyStimulus(5'b00000, 5'b00000);
    applyStimulus(5'b00000, 5'b00000);

    mon_on = 1'b0;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
